// File: rtl/bfm_apbslave_pkg.sv
// -----------------------------------------------------------------------------
// bfm_apbslave_pkg
// Shared definitions for the APB completer model: FSM state encoding, default
// parameter values, address-decode constants and the address error check.
// -----------------------------------------------------------------------------
package bfm_apbslave_pkg;

  // Default parameter values for the completer.
  localparam int DEF_MEM_AWIDTH  = 8;
  localparam int DEF_WAIT_CYCLES = 2;

  // Data path width and wait counter width (supports 0..15 wait states).
  localparam int DATA_W = 32;
  localparam int WAIT_W = 4;

  // Byte offset inside a 32-bit word; a legal access has offset zero.
  localparam int              BYTE_OFF_W     = 2;
  localparam logic [1:0]      ALIGNED_OFFSET = 2'b00;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  // An access errors when it is not word aligned or when any address bit
  // above the implemented word range is set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned awidth);
    logic [31:0] high_bits;
    high_bits = addr >> (awidth + BYTE_OFF_W);
    return (addr[BYTE_OFF_W-1:0] != ALIGNED_OFFSET) || (high_bits != '0);
  endfunction

endpackage

// File: rtl/bfm_apbslave_ram.sv
// -----------------------------------------------------------------------------
// bfm_apbslave_ram
// Word storage for the APB completer: 2^AWIDTH x 32-bit words, synchronous
// write, combinational read. Contents start at zero and have no reset, so they
// survive a reset of the surrounding logic.
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   addr   - word address shared by read and write
//   wdata  - write data
//   rdata  - combinational read data at addr
// -----------------------------------------------------------------------------
module bfm_apbslave_ram
  import bfm_apbslave_pkg::*;
#(
  parameter int AWIDTH = DEF_MEM_AWIDTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << AWIDTH;

  // Zero contents from time 0 so unwritten words read back as zero.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bfm_apbslave.sv
// -----------------------------------------------------------------------------
// bfm_apbslave
// APB completer model backed by a small word memory, with optional wait-state
// insertion and an error response for unaligned or out-of-range addresses.
// Configuration macro:
//   BFM_APBSLAVE_WAIT_EN - when defined, each transfer holds PREADY low for
//                          WAIT_CYCLES access cycles; when undefined, PREADY
//                          is constant 1 and WAIT_CYCLES is ignored.
// Ports:
//   PCLK     - clock, rising edge
//   PRESETN  - asynchronous active-low reset
//   PSEL     - completer select
//   PENABLE  - access-phase indicator
//   PWRITE   - 1 = write, 0 = read
//   PADDR    - byte address
//   PWDATA   - write data
//   PRDATA   - read data, nonzero only on a completing error-free read
//   PREADY   - transfer-complete indicator
//   PSLVERR  - error response on the completing cycle
// -----------------------------------------------------------------------------
module bfm_apbslave
  import bfm_apbslave_pkg::*;
#(
  parameter int MEM_AWIDTH  = DEF_MEM_AWIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic                   ready;
  logic                   complete;
  logic                   mem_we;
  logic [MEM_AWIDTH-1:0]  word_addr;
  logic [DATA_W-1:0]      mem_rdata;

`ifdef BFM_APBSLAVE_WAIT_EN
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  assign ready = (state_q != S_ACCESS) || (cnt_q == '0);
`else
  // Wait states are compiled out; the parameter is kept only for a uniform
  // instantiation interface.
  logic wait_cycles_unused;
  assign wait_cycles_unused = (WAIT_CYCLES != 0);
  assign ready = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    err_d   = err_q;
    mem_we  = 1'b0;
`ifdef BFM_APBSLAVE_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Only a proper setup phase starts a transfer; a stray PENABLE is ignored.
        if (PSEL && !PENABLE) begin
          state_d = S_ACCESS;
          addr_d  = PADDR;
          write_d = PWRITE;
          err_d   = addr_err(PADDR, MEM_AWIDTH);
`ifdef BFM_APBSLAVE_WAIT_EN
          cnt_d   = WAIT_INIT;
`endif
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          // Requester abandoned the transfer: no memory side effect.
          state_d = S_IDLE;
        end else if (PENABLE) begin
          if (ready) begin
            state_d = S_IDLE;
            mem_we  = write_q && !err_q;
          end
`ifdef BFM_APBSLAVE_WAIT_EN
          else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef BFM_APBSLAVE_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
`ifdef BFM_APBSLAVE_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign word_addr = addr_q[MEM_AWIDTH+1:BYTE_OFF_W];

  bfm_apbslave_ram #(
    .AWIDTH (MEM_AWIDTH)
  ) u_ram (
    .clk   (PCLK),
    .we    (mem_we),
    .addr  (word_addr),
    .wdata (PWDATA),
    .rdata (mem_rdata)
  );

  // Response signals are only driven while the access phase is completing.
  assign complete = (state_q == S_ACCESS) && ready;
  assign PREADY   = ready;
  assign PSLVERR  = complete && err_q;
  assign PRDATA   = (complete && !write_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_bfm_apbslave.sv
// -----------------------------------------------------------------------------
// tb_bfm_apbslave
// Directed testbench for bfm_apbslave. Expected latencies follow the build:
// with BFM_APBSLAVE_WAIT_EN defined each transfer takes 2+WAIT_CYCLES cycles,
// otherwise 2 cycles.
// -----------------------------------------------------------------------------
module tb_bfm_apbslave;

  localparam int MEM_AWIDTH  = 8;
  localparam int WAIT_CYCLES = 2;
`ifdef BFM_APBSLAVE_WAIT_EN
  localparam int EXP_WAIT = WAIT_CYCLES;
`else
  localparam int EXP_WAIT = 0;
`endif
  localparam int EXP_CYCLES = 2 + EXP_WAIT;

  logic        PCLK;
  logic        PRESETN;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  bfm_apbslave #(
    .MEM_AWIDTH  (MEM_AWIDTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Drives one complete APB transfer and reports what was seen on the
  // completing cycle plus the setup-to-completion cycle count.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int cycles);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cycles = 2;
    @(negedge PCLK);
    while (!PREADY && cycles <= 40) begin
      @(posedge PCLK); #1;
      cycles++;
      @(negedge PCLK);
    end
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESETN = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    #3;
    n_checks++;
    if (PREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_pready got %b want 1", PREADY); end
    n_checks++;
    if (PSLVERR !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pslverr got %b want 0", PSLVERR); end
    n_checks++;
    if (PRDATA !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_prdata got %h want 0", PRDATA); end
    // A setup phase while reset is held must not start a transfer.
    PSEL = 1'b1;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_hold got ready=%b err=%b want 1/0", PREADY, PSLVERR);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1; PRESETN = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b0, 32'h40, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL unwritten_read got %h err=%b want 00000000 err=0", rd, err);
    end
    apb_xfer(1'b1, 32'h0, 32'hA5A5_0000, rd, err, cyc);
    apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, rd, err, cyc);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL write10_err got %b want 0", err); end
    n_checks++;
    if (cyc !== EXP_CYCLES) begin n_fail++; $display("[TB] FAIL write10_cycles got %0d want %0d", cyc, EXP_CYCLES); end
    apb_xfer(1'b0, 32'h10, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL read10_data got %h want deadbeef", rd); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL read10_err got %b want 0", err); end
    n_checks++;
    if (cyc !== EXP_CYCLES) begin n_fail++; $display("[TB] FAIL read10_cycles got %0d want %0d", cyc, EXP_CYCLES); end
    apb_xfer(1'b1, 32'h3FC, 32'hCAFE_F00D, rd, err, cyc);
    apb_xfer(1'b0, 32'h3FC, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'hCAFE_F00D || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL top_word got %h err=%b want cafef00d err=0", rd, err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b0, 32'h400, 32'h0, rd, err, cyc);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_read_err got %b want 1", err); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL oor_read_data got %h want 0", rd); end
    apb_xfer(1'b1, 32'h402, 32'hBAD0_BAD0, rd, err, cyc);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL unaligned_write_err got %b want 1", err); end
    n_checks++;
    if (cyc !== EXP_CYCLES) begin n_fail++; $display("[TB] FAIL unaligned_write_cycles got %0d want %0d", cyc, EXP_CYCLES); end
    apb_xfer(1'b0, 32'h0, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'hA5A5_0000 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL word0_kept got %h err=%b want a5a50000 err=0", rd, err);
    end
    apb_xfer(1'b0, 32'h8000_0010, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL msb_addr got %h err=%b want 00000000 err=1", rd, err);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'h1234_5678;
    @(posedge PCLK); #1;
    if (EXP_WAIT > 0) begin
      PENABLE = 1'b1;
      @(posedge PCLK); @(negedge PCLK);
      n_checks++;
      if (PREADY !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_waiting got %b want 0", PREADY); end
      @(posedge PCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_idle got ready=%b err=%b want 1/0", PREADY, PSLVERR);
    end
    apb_xfer(1'b0, 32'h30, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_nowrite got %h err=%b want 00000000 err=0", rd, err);
    end
  endtask

  task automatic test_stray_enable();
    logic [31:0] rd; logic err; int cyc;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'hFFFF_FFFF;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    n_checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      n_fail++; $display("[TB] FAIL stray_enable got ready=%b err=%b data=%h want 1/0/00000000", PREADY, PSLVERR, PRDATA);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_xfer(1'b0, 32'h10, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL stray_nowrite got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h0BAD_F00D;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (EXP_WAIT > 0) begin
      @(posedge PCLK); #1;
    end
    PRESETN = 1'b0;
    #1;
    n_checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs got ready=%b err=%b data=%h want 1/0/00000000", PREADY, PSLVERR, PRDATA);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESETN = 1'b1;
    apb_xfer(1'b0, 32'h10, 32'h0, rd, err, cyc);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreset_retained got %h err=%b want deadbeef err=0", rd, err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_abort();
    test_stray_enable();
    test_reset_mid();
    repeat (2) @(posedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t want completion before 200000", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
